// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID hazard control slice.
package pipe_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DCNT_W  = 4;

    localparam logic [INSTR_W-1:0] NOP_FLUSH = 32'hE000_0000;
    localparam logic [INSTR_W-1:0] NOP_HALT  = 32'hB400_0000;

    typedef enum logic [SEL_W-1:0] {
        SEL_PASS  = 2'b00,
        SEL_FLUSH = 2'b01,
        SEL_HALT  = 2'b10
    } if_id_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        HDRAIN = 2'd2,
        HALTED = 2'd3
    } state_e;

    // IF/ID input mux used by the register that consumes if_id_sel.
    function automatic logic [INSTR_W-1:0] if_id_mux(input logic [SEL_W-1:0] sel,
                                                     input logic [INSTR_W-1:0] fetched);
        case (sel)
            SEL_FLUSH: if_id_mux = NOP_FLUSH;
            SEL_HALT:  if_id_mux = NOP_HALT;
            default:   if_id_mux = fetched;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc, holding at all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// PC / IF/ID sequencing: load-use stalls, branch flushes and halt drain.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned DRAIN_CYCLES      = 3,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_halt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [SEL_W-1:0] if_id_sel,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [DCNT_W-1:0] LS_RELOAD = DCNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DR_RELOAD = DCNT_W'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DCNT_W-1:0] cnt_q, cnt_d;
    logic              hazard;
    logic              stall_inc;
    logic              flush_inc;

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    // Next state, down-counter and combinational pipeline controls.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_sel    = SEL_PASS;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_sel    = SEL_FLUSH;
            id_ex_bubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LSTALL;
                            cnt_d   = LS_RELOAD;
                        end
                    end else if (id_is_halt) begin
                        pc_write  = 1'b0;
                        if_id_sel = SEL_HALT;
                        if (DRAIN_CYCLES > 1) begin
                            state_d = HDRAIN;
                            cnt_d   = DR_RELOAD;
                        end else begin
                            state_d = HALTED;
                        end
                    end else if (id_branch_taken) begin
                        if_id_sel = SEL_FLUSH;
                        flush_inc = 1'b1;
                    end
                end
                LSTALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - DCNT_W'(1);
                    if (cnt_q <= DCNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                HDRAIN: begin
                    pc_write     = 1'b0;
                    if_id_sel    = SEL_HALT;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - DCNT_W'(1);
                    if (cnt_q <= DCNT_W'(1)) begin
                        state_d = HALTED;
                        cnt_d   = '0;
                    end
                end
                HALTED: begin
                    pc_write     = 1'b0;
                    if_id_sel    = SEL_HALT;
                    id_ex_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and down-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the IF/ID pipeline register and the PC.
- Decides each cycle whether IF/ID loads a new instruction, holds, is flushed with a NOP, or is loaded with the HALT instruction.
- Detects load-use hazards (EX load vs ID sources), branch-taken flushes resolved in ID, and the halt/drain sequence.
- Keeps saturating stall and flush event counters for debug.
- Sits between the decode/EX control signals and the PC, IF/ID and ID/EX registers.

Parameters:
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7).
- DRAIN_CYCLES, 3, cycles after HALT is captured before the halted flag asserts (pipeline drain to WB, 1..15).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  ID-stage source register rs.
- id_rt  in  5  ID-stage source register rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_halt  in  1  ID instruction opcode is 101101.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable; 0 means hold.
- if_id_sel  out  2  IF/ID input select: 00 = pass fetched instruction, 01 = flush NOP 32'hE000_0000, 10 = HALT 32'hB400_0000.
- id_ex_bubble  out  1  zero the control fields into ID/EX.
- halted  out  1  core halted, sticky until reset.
- stall_cnt  out  CNT_W  load-use stall events, saturating.
- flush_cnt  out  CNT_W  branch flush events, saturating.

Behaviour:
- State register states: RUN, LSTALL, HDRAIN, HALTED. Down-counter cnt is 4 bits wide.
- Outputs are combinational from state and inputs. State, cnt and the event counters are registered.
- hazard = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- During reset and the cycle it is sampled:
  - State = RUN, cnt = 0, counters = 0, halted = 0.
  - pc_write = 0, if_id_write = 1, if_id_sel = 01, id_ex_bubble = 1, so the pipeline is filled with NOP.
- RUN, priority hazard > id_is_halt > id_branch_taken > normal:
  - hazard: pc_write = 0, if_id_write = 0, id_ex_bubble = 1, stall_cnt += 1.
    - If LOAD_STALL_CYCLES > 1: go to LSTALL with cnt = LOAD_STALL_CYCLES-1.
    - Otherwise stay in RUN; the hazard clears next cycle as the load leaves EX.
  - id_is_halt: pc_write = 0, if_id_write = 1, if_id_sel = 10, id_ex_bubble = 0 (the HALT passes to EX). Go to HDRAIN with cnt = DRAIN_CYCLES-1.
  - id_branch_taken: pc_write = 1 (target), if_id_write = 1, if_id_sel = 01, id_ex_bubble = 0, flush_cnt += 1. Exactly one-cycle flush.
  - normal: pc_write = 1, if_id_write = 1, if_id_sel = 00, id_ex_bubble = 0.
- LSTALL: same outputs as the hazard case, no counter increment. cnt decrements; when cnt == 0, go to RUN.
  - id_branch_taken and id_is_halt are ignored in this state; they are re-evaluated in RUN with a valid operand.
- HDRAIN: pc_write = 0, if_id_write = 1, if_id_sel = 10, id_ex_bubble = 1. cnt decrements; when cnt == 0, go to HALTED.
- HALTED: outputs as HDRAIN, and halted = 1. Exit only by reset.
- Simultaneous hazard and branch: the stall wins. The branch is re-evaluated after the stall; no flush count is taken that cycle.
- Simultaneous halt and branch: the halt wins.
- Counters saturate at all ones, with no wrap.
- Reset mid-stall or mid-drain: returns to RUN next cycle with all counters cleared.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_FLUSH = 32'hE000_0000 and NOP_HALT = 32'hB400_0000.
  - The if_id_sel encodings SEL_PASS, SEL_FLUSH and SEL_HALT.
  - The state enum.
- One sub-module sat_counter (parameter W; inputs clk, reset, inc; output q) is used twice, for stall_cnt and flush_cnt.
- The IF/ID register consumes if_id_sel and selects the package constants.

Test Plan:
- Reset held 2 cycles, then released, no hazards -> while reset: pc_write = 0, if_id_sel = 01, id_ex_bubble = 1. After release: pc_write = 1, if_id_sel = 00, counters = 0.
- Load-use hazard, ex_mem_read = 1, ex_rd = 8, id_rs = 8, id_uses_rs = 1, one cycle:
  - pc_write = 0, if_id_write = 0, id_ex_bubble = 1 for 1 cycle, stall_cnt = 1.
  - The same with ex_rd = 0 -> no stall.
- LOAD_STALL_CYCLES = 3, single hazard pulse -> 3 consecutive stall cycles, stall_cnt = 1. An id_branch_taken pulse in cycle 2 is ignored (flush_cnt = 0).
- id_branch_taken one cycle -> if_id_sel = 01 and pc_write = 1 for exactly 1 cycle, flush_cnt = 1. Hazard plus branch in the same cycle -> stall only, flush_cnt unchanged.
- id_is_halt at cycle T (DRAIN_CYCLES = 3):
  - if_id_sel = 10 and pc_write = 0 from cycle T.
  - halted = 1 from T+3, stays 1 under random inputs.
  - Reset at T+5 -> RUN and halted = 0.
- Force 2^CNT_W+2 hazard events (CNT_W = 4) -> stall_cnt saturates at 15 with no wrap.
